quad_enc_gen: RTL

Quadrature encoder stimulus generator: accepts a "move N detents in direction D" command over a ready/valid handshake and drives `q_a`/`q_b` with the correctly phased quadrature sequence, holding each phase for a programmable number of clocks. It is the transmit end of the rotary-encoder interface consumed by the rotation counter. It serves both as a board-level encoder emulator and as a bench driver. An optional glitch injection produces an illegal double-bit transition so the counter's error path can be exercised.

---
 rtl/quad_enc_pkg.sv | 26 ++
 rtl/quad_phase_timer.sv | 32 +++
 rtl/quad_enc_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg
// Shared types and constants for the quadrature encoder generator.
//   state_t     : FSM states (IDLE, RUN, GAP)
//   phase_t     : 2-bit quadrature phase, wraps modulo 4
//   PHASE_AB    : phase -> {q_a,q_b} lookup (0:00, 1:10, 2:11, 3:01)
//   UP / DOWN   : direction encodings for cmd_dir
package quad_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic [1:0] PHASE_AB [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    function automatic logic [1:0] phase_to_ab(input phase_t p);
        return PHASE_AB[p];
    endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// quad_phase_timer
// Loadable down-counter used to time phase holds and inter-detent gaps.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : count is zero; counting stops there until the next load
module quad_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/quad_enc_gen.sv
// quad_enc_gen
// Quadrature encoder stimulus generator. Accepts "move N detents in
// direction D" and drives q_a/q_b with the phased quadrature sequence,
// each phase held STEP_CYCLES clocks, with GAP_CYCLES clocks at 00 between
// detents. Optional glitch makes the first transition jump two phases.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_valid seen
// while busy is ignored (not queued) and the source must hold the command
// until it sees cmd_ready.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cmd_valid     : command present
//   cmd_ready     : generator idle and able to accept (registered)
//   cmd_dir       : 1 = up (A leads B), 0 = down
//   cmd_count     : number of detents to emit
//   cmd_glitch    : corrupt the first transition of the command
//   q_a, q_b      : registered quadrature outputs
//   busy          : command in progress
//   done          : one-cycle pulse on command completion
//   detents_left  : remaining detents of the current command
//   fsm_state     : current FSM state (debug visibility)
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_glitch,
    output logic             q_a,
    output logic             q_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] detents_left,
    output logic [1:0]       fsm_state
);

    localparam int MAX_C = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = (GAP_CYCLES == 0) ? '0 : TW'(GAP_CYCLES - 1);

    state_t           state, state_n;
    phase_t           phase, phase_n, step;
    logic             dir_r, dir_n;
    logic             glitch_r, glitch_n;
    logic             done_n;
    logic [CNT_W-1:0] left_n;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;

    quad_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // A pending glitch makes the next transition a double step (00 -> 11).
    assign step = glitch_r ? 2'd2 : 2'd1;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        dir_n    = dir_r;
        glitch_n = glitch_r;
        left_n   = detents_left;
        done_n   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_n    = cmd_dir;
                    glitch_n = cmd_glitch;
                    left_n   = cmd_count;
                    if (cmd_count != '0) begin
                        state_n  = RUN;
                        tmr_load = 1'b1;
                        tmr_val  = STEP_LD;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            RUN: begin
                if (tmr_zero) begin
                    phase_n  = (dir_r == UP) ? phase + step : phase - step;
                    glitch_n = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = STEP_LD;
                    // Landing on phase 0 closes a detent.
                    if (phase_n == 2'd0) begin
                        left_n = detents_left - CNT_W'(1);
                        if (left_n == '0) begin
                            state_n  = IDLE;
                            done_n   = 1'b1;
                            tmr_load = 1'b0;
                        end else if (GAP_CYCLES != 0) begin
                            state_n = GAP;
                            tmr_val = GAP_LD;
                        end
                    end
                end
            end

            GAP: begin
                if (tmr_zero) begin
                    state_n  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = STEP_LD;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= 2'd0;
            q_a          <= 1'b0;
            q_b          <= 1'b0;
            dir_r        <= 1'b0;
            glitch_r     <= 1'b0;
            detents_left <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            {q_a, q_b}   <= phase_to_ab(phase_n);
            dir_r        <= dir_n;
            glitch_r     <= glitch_n;
            detents_left <= left_n;
            done         <= done_n;
            busy         <= (state_n != IDLE);
            cmd_ready    <= (state_n == IDLE);
        end
    end

    assign fsm_state = state;

endmodule
